// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                              |
// | Description : Round-robin arbiter sharing one UART transmitter between     |
// |               NUM_REQ byte producers on the baud clock. One start pulse    |
// |               and one ack per byte; a watchdog aborts a frame whose done   |
// |               pulse never arrives.                                         |
// |               Optional: define UART_ARB_LOCK_EN to keep the grant on one   |
// |               requester until it sends a byte flagged with req_last.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
    parameter int  NUM_REQ     = 4,
    parameter int  TIMEOUT_CYC = 16,
    localparam int GRANT_W     = $clog2(NUM_REQ)
) (
    input  logic                 clk_baud,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           uart_tx_byte,
    output logic                 uart_start_send,
    input  logic                 uart_done,
    output logic                 busy,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    localparam logic [CNT_W-1:0]   c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [GRANT_W-1:0] c_gid_rst  = GRANT_W'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [GRANT_W-1:0] r_grant_id;
    logic [7:0]         r_tx_byte;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_start;
    logic               r_timeout_err;

    logic               w_rr_found;
    logic [GRANT_W-1:0] w_rr_winner;
    logic               w_lock_hold;
    logic               w_found;
    logic [GRANT_W-1:0] w_winner;
    logic [7:0]         w_byte;
    logic               w_timeout;

    // Round-robin search: first pending requester after the last grant, wrapping at NUM_REQ-1
    always_comb begin
        logic [GRANT_W-1:0] v_idx;
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        v_idx       = '0;
        // Scan from farthest to nearest so the nearest pending requester wins
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = GRANT_W'((int'(r_grant_id) + k) % NUM_REQ);
            if (req[v_idx]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = v_idx;
            end
        end
    end

`ifdef UART_ARB_LOCK_EN
    logic r_locked;

    // A locked requester that is still pending keeps the grant regardless of round-robin order
    assign w_lock_hold = r_locked && req[r_grant_id];
`else
    logic w_unused_last;

    assign w_lock_hold   = 1'b0;
    assign w_unused_last = ^req_last;
`endif

    assign w_found   = w_lock_hold | w_rr_found;
    assign w_winner  = w_lock_hold ? r_grant_id : w_rr_winner;
    assign w_timeout = (r_state == c_st_wait) && !uart_done && (r_wait_cnt == c_cnt_last);

    // Byte mux for the winning requester
    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == GRANT_W'(i)) begin
                w_byte = req_byte[8*i +: 8];
            end
        end
    end

    // Main FSM: pick a winner in IDLE, pulse start/ack out of ISSUE, wait for done or watchdog
    always_ff @(posedge clk_baud or negedge rst) begin
        if (!rst) begin
            r_state       <= c_st_idle;
            r_wait_cnt    <= '0;
            r_grant_id    <= c_gid_rst;
            r_tx_byte     <= 8'h00;
            r_ack         <= '0;
            r_start       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_ack         <= '0;
            r_start       <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_grant_id <= w_winner;
                        r_tx_byte  <= w_byte;
                        r_state    <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_ack      <= NUM_REQ'(1) << r_grant_id;
                    r_start    <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= c_st_wait;
                end
                c_st_wait: begin
                    if (uart_done) begin
                        r_state <= c_st_idle;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= c_st_idle;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef UART_ARB_LOCK_EN
    // Lock tracking: set on a non-final byte, cleared on final byte, holder withdrawal or timeout
    always_ff @(posedge clk_baud or negedge rst) begin
        if (!rst) begin
            r_locked <= 1'b0;
        end else if (r_state == c_st_idle) begin
            if (w_found) begin
                r_locked <= !req_last[w_winner];
            end else begin
                r_locked <= 1'b0;
            end
        end else if (w_timeout) begin
            r_locked <= 1'b0;
        end
    end
`endif

    assign ack             = r_ack;
    assign uart_start_send = r_start;
    assign uart_tx_byte    = r_tx_byte;
    assign grant_id        = r_grant_id;
    assign timeout_err     = r_timeout_err;
    assign busy            = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                           |
// | Description : Randomized self-checking bench for uart_tx_arbiter with a    |
// |               transaction-level model of grants, frames and the watchdog.  |
// |               Honours UART_ARB_LOCK_EN when defined.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int GW  = 2;
    localparam int BIG = 32'h3fff_ffff;

    logic            clk_baud = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*8-1:0]  req_byte;
    logic [N-1:0]    req_last;
    logic [N-1:0]    ack;
    logic [7:0]      uart_tx_byte;
    logic            uart_start_send;
    logic            uart_done;
    logic            busy;
    logic [GW-1:0]   grant_id;
    logic            timeout_err;

    logic            rq [N];
    logic [7:0]      rb [N];
    logic            rl [N];

    always #5 clk_baud = ~clk_baud;

    // Pack the per-requester stimulus arrays onto the DUT buses
    always_comb begin
        req      = '0;
        req_byte = '0;
        req_last = '0;
        for (int i = 0; i < N; i++) begin
            req[i]            = rq[i];
            req_byte[8*i +: 8] = rb[i];
            req_last[i]       = rl[i];
        end
    end

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TMO)
    ) u_dut (
        .clk_baud        (clk_baud),
        .rst             (rst),
        .req             (req),
        .req_byte        (req_byte),
        .req_last        (req_last),
        .ack             (ack),
        .uart_tx_byte    (uart_tx_byte),
        .uart_start_send (uart_start_send),
        .uart_done       (uart_done),
        .busy            (busy),
        .grant_id        (grant_id),
        .timeout_err     (timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model state (transaction level)
    int cyc, last_grant, free_from, ack_cyc, done_at, tmo_at, frame_start;
    int exp_w, shown_gid, lock_id, phase;
    logic [7:0] exp_byte, shown_byte;
    bit locked, rst_done, any_req, withhold;

    function automatic int rr_pick(input int last);
        for (int k = 1; k <= N; k++) begin
            if (rq[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},      32'(ack), 32'd0);
        chk({tag, "_start"},    32'(uart_start_send), 32'd0);
        chk({tag, "_txbyte"},   32'(uart_tx_byte), 32'd0);
        chk({tag, "_busy"},     32'(busy), 32'd0);
        chk({tag, "_timeout"},  32'(timeout_err), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'(N - 1));
    endtask

    task automatic model_reset();
        last_grant  = N - 1;
        shown_gid   = N - 1;
        shown_byte  = 8'h00;
        free_from   = cyc;
        ack_cyc     = -1;
        done_at     = -1;
        tmo_at      = -1;
        frame_start = -1;
        locked      = 1'b0;
        lock_id     = 0;
    endtask

    initial begin
        rst       = 1'b0;
        uart_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            rq[i] = 1'b0;
            rb[i] = 8'h00;
            rl[i] = 1'b0;
        end
        rst_done = 1'b0;
        repeat (3) @(posedge clk_baud);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        cyc = 0;
        model_reset();

        for (int it = 0; it < 4000; it++) begin
            @(posedge clk_baud);
            #1;
            cyc++;
            phase = (cyc < 20) ? 1 : (cyc < 300) ? 2 : 3;

            // Compare DUT outputs against the model for this cycle
            if (cyc == frame_start) begin
                shown_gid  = exp_w;
                shown_byte = exp_byte;
            end
            chk("ack",         32'(ack), (cyc == ack_cyc) ? (32'd1 << exp_w) : 32'd0);
            chk("start_send",  32'(uart_start_send), 32'(cyc == ack_cyc));
            chk("timeout_err", 32'(timeout_err), 32'(cyc == tmo_at));
            chk("busy",        32'(busy), 32'(cyc >= frame_start && cyc < free_from));
            chk("grant_id",    32'(grant_id), 32'(shown_gid));
            chk("tx_byte",     32'(uart_tx_byte), 32'(shown_byte));

            // Byte accepted: decide the transmitter's response, requester consumes the byte
            if (cyc == ack_cyc) begin
                withhold = (phase == 3) && ($urandom_range(0, 4) == 0);
                if (withhold) begin
                    tmo_at    = cyc + TMO;
                    free_from = cyc + TMO;
                    locked    = 1'b0;
                end else begin
                    done_at   = cyc + 10;
                    free_from = cyc + 11;
                end
                if (phase >= 2 && $urandom_range(0, 99) < ((phase == 2) ? 100 : 50)) begin
                    rb[exp_w] = (phase == 2) ? 8'(8'h10 + exp_w + 4 * ($urandom_range(1, 15))) : 8'($urandom);
                    rl[exp_w] = ($urandom_range(0, 2) == 0);
                end else begin
                    rq[exp_w] = 1'b0;
                end
            end

            // Asynchronous reset in the middle of a WAIT frame
            if (phase == 3 && !rst_done && cyc >= 2000 && cyc > ack_cyc && cyc < free_from - 2) begin
                rst_done  = 1'b1;
                rst       = 1'b0;
                uart_done = 1'b0;
                #1;
                check_reset_outputs("midrst");
                @(posedge clk_baud);
                #1;
                cyc++;
                check_reset_outputs("midrst_hold");
                rst = 1'b1;
                model_reset();
            end

            // Transmitter: done on schedule, plus stray pulses while the arbiter is not waiting
            uart_done = (cyc == done_at) ||
                        ((phase == 3) && !(cyc >= ack_cyc && cyc < free_from) &&
                         ($urandom_range(0, 19) == 0));

            // Requesters
            if (phase == 1) begin
                if (cyc == 3) begin
                    rq[0] = 1'b1;
                    rb[0] = 8'hA5;
                    rl[0] = 1'b1;
                end
            end else begin
                for (int j = 0; j < N; j++) begin
                    if (!rq[j]) begin
                        if ($urandom_range(0, 99) < ((phase == 2) ? 100 : 8)) begin
                            rq[j] = 1'b1;
                            rb[j] = (phase == 2) ? 8'(8'h10 + j) : 8'($urandom);
                            rl[j] = ($urandom_range(0, 2) == 0);
                        end
                    end else if (phase == 3 && cyc >= free_from && $urandom_range(0, 199) == 0) begin
                        rq[j] = 1'b0;
                    end
                end
            end

            // Arbitration decision while the arbiter is idle
            if (cyc >= free_from) begin
                if (locked && !rq[lock_id]) locked = 1'b0;
                any_req = 1'b0;
                for (int j = 0; j < N; j++) any_req |= rq[j];
                if (any_req) begin
                    exp_w       = locked ? lock_id : rr_pick(last_grant);
                    exp_byte    = rb[exp_w];
`ifdef UART_ARB_LOCK_EN
                    locked      = !rl[exp_w];
`endif
                    lock_id     = exp_w;
                    last_grant  = exp_w;
                    frame_start = cyc + 1;
                    ack_cyc     = cyc + 2;
                    free_from   = BIG;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
